// File: rtl/dmem_mmio_if.sv
// Bus bundle between the MEM stage (plus the TX consumer) and dmem_mmio.
// The master side drives the address/write lanes and the drain-ready signal.
interface dmem_mmio_if;
    logic [31:0] addr;
    logic [3:0]  w_en;
    logic [31:0] w_data;
    logic [31:0] r_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output addr, w_en, w_data, tx_ready,
        input  r_data, tx_data, tx_valid
    );

    modport slave (
        input  addr, w_en, w_data, tx_ready,
        output r_data, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_mmio.sv
// Data memory plus MMIO slave: byte-writable word RAM, TX FIFO and STATUS register.
// Define DMEM_MMIO_CYCLE_CNT_EN to build the 64-bit free-running cycle counter.
module dmem_mmio #(
    parameter int DEPTH_WORDS = 16384,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    dmem_mmio_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [3:0][7:0] ram [DEPTH_WORDS];
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            ovf;

    logic            mmio_sel;
    logic [1:0]      reg_sel;
    logic [AW-1:0]   word_idx;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            push_req;
    logic            push;
    logic            ovf_set;
    logic            ovf_clr;
    logic            ram_we;
    logic [3:0]      count4;
    logic [31:0]     cycle_lo;
    logic [31:0]     cycle_hi;
    logic            unused_addr;

    assign mmio_sel   = bus.addr[31];
    assign reg_sel    = bus.addr[3:2];
    assign word_idx   = bus.addr[AW+1:2];
    assign unused_addr = ^{bus.addr[30:AW+2], bus.addr[1:0]};

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign pop        = !fifo_empty && bus.tx_ready;
    assign push_req   = mmio_sel && (reg_sel == 2'd0) && bus.w_en[0];
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push       = push_req && (!fifo_full || pop);
    assign ovf_set    = push_req && fifo_full && !pop;
    assign ovf_clr    = mmio_sel && (reg_sel == 2'd1) && bus.w_en[0] && bus.w_data[2];
    assign ram_we     = !mmio_sel && (bus.w_en != 4'h0);
    assign count4     = 4'(count);

    // RAM has no reset; the rst gate drops stores that land while reset is held.
    always_ff @(posedge clk) begin
        if (rst && ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.w_en[i]) ram[word_idx][i] <= bus.w_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= 8'h00;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bus.w_data[7:0];
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

`ifdef DMEM_MMIO_CYCLE_CNT_EN
    logic [63:0] cycle_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cycle_cnt <= '0;
        else      cycle_cnt <= cycle_cnt + 64'd1;
    end

    assign cycle_lo = cycle_cnt[31:0];
    assign cycle_hi = cycle_cnt[63:32];
`else
    assign cycle_lo = 32'h0;
    assign cycle_hi = 32'h0;
`endif

    assign bus.tx_valid = !fifo_empty;
    assign bus.tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

    always_comb begin
        bus.r_data = 32'h0;
        if (!mmio_sel) begin
            bus.r_data = ram[word_idx];
        end else begin
            case (reg_sel)
                2'd1:    bus.r_data = {24'h0, count4, ovf, fifo_full, fifo_empty};
                2'd2:    bus.r_data = cycle_lo;
                2'd3:    bus.r_data = cycle_hi;
                default: bus.r_data = 32'h0;
            endcase
        end
    end
endmodule
